pulse_code_rx: RTL and testbench

- Receive-side counterpart of the transceiver's pulse-code link.
- Samples a serial line carrying 8-bit pulse codewords, sent MSB first, one bit cell per CLKS_PER_BIT clocks.
- Recovers each frame, validates it against the four legal symbol codewords and emits a 2-bit symbol with a one-cycle valid strobe.
- Feeds the receiver's symbol consumer and its 7-segment display path.

---
 rtl/pulse_code_pkg.sv | 33 +++
 rtl/pulse_rx_sync.sv | 34 +++
 rtl/pulse_code_rx.sv | 151 +++++++++++++++
 tb/tb_pulse_code_rx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_code_pkg.sv
// Shared definitions for the pulse-code link: codeword constants, receiver FSM
// states and the codeword decoder used by both the TX encoder and the receiver.
package pulse_code_pkg;

  localparam int CODE_W = 8;

  localparam logic [CODE_W-1:0] CW_SYM0 = 8'h80;
  localparam logic [CODE_W-1:0] CW_SYM1 = 8'hA0;
  localparam logic [CODE_W-1:0] CW_SYM2 = 8'hA8;
  localparam logic [CODE_W-1:0] CW_SYM3 = 8'hAA;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_DONE
  } rx_state_e;

  // Returns {legal, symbol}; illegal codewords return 3'b000.
  function automatic logic [2:0] decode_code(input logic [CODE_W-1:0] c);
    logic [2:0] r;
    r = 3'b000;
    case (c)
      CW_SYM0: r = {1'b1, 2'd0};
      CW_SYM1: r = {1'b1, 2'd1};
      CW_SYM2: r = {1'b1, 2'd2};
      CW_SYM3: r = {1'b1, 2'd3};
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pulse_rx_sync.sv
// Metastability synchronizer for the asynchronous serial line plus a
// rising-edge detector on the synchronized value.
module pulse_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_in,
  output logic rx_sync,
  output logic rx_rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rx_sync = sync_q[SYNC_STAGES-1];
  assign rx_rise = rx_sync & ~prev_q;

endmodule

// File: rtl/pulse_code_rx.sv
// Pulse-code link receiver: recovers MSB-first 8-bit codewords and decodes them
// to 2-bit symbols. Define PULSE_RX_ERRCNT_EN to add the saturating err_cnt port.
module pulse_code_rx
  import pulse_code_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_in,
  output logic [CODE_W-1:0] code,
  output logic [1:0]        symbol,
  output logic              sym_valid,
  output logic              frame_err,
`ifdef PULSE_RX_ERRCNT_EN
  output logic [7:0]        err_cnt,
`endif
  output logic              busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic rx_sync, rx_rise;

  pulse_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .rx_in  (rx_in),
    .rx_sync(rx_sync),
    .rx_rise(rx_rise)
  );

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [CODE_W-1:0] shift_q, shift_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [1:0]        symbol_q, symbol_d;
  logic              sym_valid_q, sym_valid_d;
  logic              frame_err_q, frame_err_d;
  logic [2:0]        dec;

  assign dec = decode_code(shift_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    code_d      = code_q;
    symbol_d    = symbol_q;
    sym_valid_d = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_rise) begin
          state_d = ST_START;
          cnt_d   = HALF_LOAD;
        end
      end
      // Mid-cell check of the start bit rejects short glitches.
      ST_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_sync) begin
          shift_d = {{(CODE_W-1){1'b0}}, 1'b1};
          cnt_d   = FULL_LOAD;
          idx_d   = 3'd6;
          state_d = ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {shift_q[CODE_W-2:0], rx_sync};
          cnt_d   = FULL_LOAD;
          if (idx_q == 3'd0) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      ST_DONE: begin
        code_d = shift_q;
        if (dec[2]) begin
          symbol_d    = dec[1:0];
          sym_valid_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      code_q      <= '0;
      symbol_q    <= '0;
      sym_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      code_q      <= code_d;
      symbol_q    <= symbol_d;
      sym_valid_q <= sym_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef PULSE_RX_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (frame_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

  assign code      = code_q;
  assign symbol    = symbol_q;
  assign sym_valid = sym_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pulse_code_rx.sv
// Directed plus randomized bench for pulse_code_rx (CLKS_PER_BIT=8, SYNC_STAGES=2)
// checked against a codeword-table reference model.
module tb_pulse_code_rx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic [7:0] code;
  logic [1:0] symbol;
  logic       sym_valid;
  logic       frame_err;
  logic       busy;
`ifdef PULSE_RX_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  pulse_code_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_in    (rx_in),
    .code     (code),
    .symbol   (symbol),
    .sym_valid(sym_valid),
    .frame_err(frame_err),
`ifdef PULSE_RX_ERRCNT_EN
    .err_cnt  (err_cnt),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int sv_cnt   = 0;
  int fe_cnt   = 0;
  int both_cnt = 0;
  int ts[$];

  // Reference model state
  int         exp_sv   = 0;
  int         exp_fe   = 0;
  logic [1:0] exp_sym  = 2'd0;
  logic [7:0] exp_code = 8'h00;
  logic [7:0] legal_tab [4] = '{8'h80, 8'hA0, 8'hA8, 8'hAA};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sym_valid === 1'b1) begin
      sv_cnt <= sv_cnt + 1;
      ts.push_back(cyc);
    end
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (sym_valid === 1'b1 && frame_err === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_frame(input logic [7:0] b);
    bit hit;
    hit = 0;
    exp_code = b;
    for (int i = 0; i < 4; i++) begin
      if (legal_tab[i] == b) begin
        hit = 1;
        exp_sym = 2'(i);
      end
    end
    if (hit) exp_sv++;
    else     exp_fe++;
  endfunction

  // Called at a negedge; each bit held for one full cell.
  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      rx_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_in = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_idle_timeout"}, (k < 200), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_sv_cnt"}, sv_cnt, exp_sv);
    check({tag, "_fe_cnt"}, fe_cnt, exp_fe);
    check({tag, "_symbol"}, symbol, exp_sym);
    check({tag, "_code"}, code, exp_code);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_both"}, both_cnt, 0);
  endtask

  initial begin
    int busy_len;
    logic [7:0] b;
    logic [7:0] rb;

    reset = 1'b1;
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_code", code, 8'h00);
    check("rst_symbol", symbol, 2'd0);
    check("rst_sym_valid", sym_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single legal frame
    send_byte(8'hA8);
    model_frame(8'hA8);
    wait_idle("t1");
    check_model("t1");
    check("t1_symbol_is_2", symbol, 2'd2);

    // 2: back-to-back frames, strobes one frame period apart
    ts.delete();
    send_byte(8'hAA);
    model_frame(8'hAA);
    send_byte(8'h80);
    model_frame(8'h80);
    wait_idle("t2");
    check_model("t2");
    check("t2_strobes", ts.size(), 2);
    if (ts.size() == 2) check("t2_spacing", ts[1] - ts[0], 64);

    // 3: legal then illegal frame
    send_byte(8'hA0);
    model_frame(8'hA0);
    wait_idle("t3a");
    check_model("t3a");
    send_byte(8'hB0);
    model_frame(8'hB0);
    wait_idle("t3b");
    check_model("t3b");
    check("t3_symbol_held", symbol, 2'd1);

    // 4: two-clock glitch is rejected
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    rx_in = 1'b0;
    busy_len = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_len++;
    end
    check("t4_busy_seen", (busy_len > 0), 1);
    check("t4_busy_short", (busy_len <= 4), 1);
    check_model("t4");

    // 5: reset during bit 4 of an A0 frame
    b = 8'hA0;
    for (int i = 7; i >= 5; i--) begin
      rx_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_in = b[4];
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_code", code, 8'h00);
    check("t5_rst_symbol", symbol, 2'd0);
    check("t5_rst_sym_valid", sym_valid, 0);
    check("t5_rst_frame_err", frame_err, 0);
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_sym  = 2'd0;
    exp_code = 8'h00;
    repeat (3) @(negedge clk);
    check_model("t5_after_rst");
    send_byte(8'hA0);
    model_frame(8'hA0);
    wait_idle("t5");
    check_model("t5");

    // Randomized mix of legal codewords and illegal start-bit-framed bytes
    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom);
      if ($urandom_range(0, 1) == 0) b = legal_tab[$urandom_range(0, 3)];
      else                           b = (rb | 8'h80) & 8'hFE;
      send_byte(b);
      model_frame(b);
      repeat (CPB * $urandom_range(0, 2)) @(negedge clk);
      wait_idle("rnd");
      check_model("rnd");
    end

`ifdef PULSE_RX_ERRCNT_EN
    // 6: saturating error counter
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sv_cnt = 0; fe_cnt = 0; exp_sv = 0; exp_fe = 0;
    exp_sym = 2'd0; exp_code = 8'h00;
    @(negedge clk);
    check("t6_cnt_rst", err_cnt, 8'h00);
    for (int n = 0; n < 3; n++) begin
      send_byte(8'hC0);
      model_frame(8'hC0);
      wait_idle("t6a");
    end
    check("t6_cnt3", err_cnt, 8'd3);
    for (int n = 0; n < 257; n++) begin
      send_byte(8'hC0);
      model_frame(8'hC0);
      repeat (CPB) @(negedge clk);
    end
    wait_idle("t6b");
    check("t6_cnt_sat", err_cnt, 8'hFF);
    check_model("t6");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
